// File: rtl/decode_issue_stage_pkg.sv
// Shared encodings for the decode/issue stage and the ALU downstream of it.
// Holds the opcode/funct constants, instruction field positions and a classifier.
package decode_issue_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;

    typedef enum logic [2:0] {
        IC_ALU,
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_ILLEGAL
    } instr_class_e;

    function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] fn);
        instr_class_e cls;
        cls = IC_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                if (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR)
                    cls = IC_ALU;
            end
            OP_LW:   cls = IC_LOAD;
            OP_SW:   cls = IC_STORE;
            OP_BEQ:  cls = IC_BRANCH;
            default: cls = IC_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decode_issue_stage_reg_file.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one write port, register 0 hardwired to zero.
module decode_issue_stage_reg_file #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A same-cycle writeback wins over the stored value so the reader never sees stale data.
    assign rs_data = (rs_addr == 5'd0)                  ? '0      :
                     (wr_en && wr_addr == rs_addr)       ? wr_data :
                                                           regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0)                  ? '0      :
                     (wr_en && wr_addr == rt_addr)       ? wr_data :
                                                           regs[rt_addr];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/operand-fetch stage: accepts instructions from fetch, reads operands,
// builds immediates and presents registered operands to the ALU.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [31:0]        if_instr,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [DATA_W-1:0]  in1,
    output logic [DATA_W-1:0]  in2,
    output logic [DATA_W-1:0]  store_data,
    output logic [4:0]         dest_reg,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               illegal,
    output logic [COUNT_W-1:0] issue_count
);

    logic [5:0]         op_f;
    logic [5:0]         fn_f;
    logic [4:0]         rs_f;
    logic [4:0]         rt_f;
    logic [4:0]         rd_f;
    logic [15:0]        imm_f;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    instr_class_e       cls;
    logic               accept;
    logic               issue;
    logic [5:0]         funct_next;
    logic [DATA_W-1:0]  in2_next;
    logic [DATA_W-1:0]  store_next;
    logic [4:0]         dest_next;
    logic               unused_shamt;

    assign op_f    = if_instr[OP_MSB:OP_LSB];
    assign fn_f    = if_instr[FN_MSB:FN_LSB];
    assign rs_f    = if_instr[RS_MSB:RS_LSB];
    assign rt_f    = if_instr[RT_MSB:RT_LSB];
    assign rd_f    = if_instr[RD_MSB:RD_LSB];
    assign imm_f   = if_instr[IMM_MSB:IMM_LSB];
    assign imm_ext = {{(DATA_W-16){imm_f[15]}}, imm_f};
    assign unused_shamt = ^if_instr[10:6];

    assign cls      = classify(op_f, fn_f);
    assign if_ready = !ex_valid || ex_ready;
    assign accept   = if_valid && if_ready;
    assign issue    = accept && (cls != IC_ILLEGAL);

    decode_issue_stage_reg_file #(.DATA_W(DATA_W)) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_f),
        .rt_addr (rt_f),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

    always_comb begin
        funct_next = (op_f == OP_RTYPE) ? fn_f : 6'd0;
        in2_next   = rt_data;
        store_next = '0;
        dest_next  = 5'd0;
        case (cls)
            IC_ALU:   dest_next = rd_f;
            IC_LOAD: begin
                in2_next  = imm_ext;
                dest_next = rt_f;
            end
            IC_STORE: begin
                in2_next   = imm_ext;
                store_next = rt_data;
            end
            default: ;
        endcase
    end

    // Data registers only move on a legal issue; otherwise they keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            illegal     <= 1'b0;
            issue_count <= '0;
            opcode      <= '0;
            funct       <= '0;
            in1         <= '0;
            in2         <= '0;
            store_data  <= '0;
            dest_reg    <= '0;
        end else begin
            illegal <= accept && (cls == IC_ILLEGAL);
            if (issue) begin
                ex_valid    <= 1'b1;
                issue_count <= issue_count + COUNT_W'(1);
                opcode      <= op_f;
                funct       <= funct_next;
                in1         <= rs_data;
                in2         <= in2_next;
                store_data  <= store_next;
                dest_reg    <= dest_next;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: a reference model pushes expected
// ALU-side outputs on accept; they are compared when the DUT presents them.
module tb_decode_issue_stage;

    localparam int DATA_W  = 32;
    localparam int COUNT_W = 4;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  dst;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               if_valid = 1'b0;
    logic               if_ready;
    logic [31:0]        if_instr = '0;
    logic               ex_valid;
    logic               ex_ready = 1'b0;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  in2;
    logic [DATA_W-1:0]  store_data;
    logic [4:0]         dest_reg;
    logic               wb_en = 1'b0;
    logic [4:0]         wb_addr = '0;
    logic [DATA_W-1:0]  wb_data = '0;
    logic               illegal;
    logic [COUNT_W-1:0] issue_count;

    int tests = 0;
    int fails = 0;

    exp_t               sb[$];
    logic [31:0]        m_regs [32];
    logic               m_ev;
    logic               m_ill;
    logic [COUNT_W-1:0] m_cnt;

    decode_issue_stage #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .opcode      (opcode),
        .funct       (funct),
        .in1         (in1),
        .in2         (in2),
        .store_data  (store_data),
        .dest_reg    (dest_reg),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_legal(input logic [31:0] i);
        case (i[31:26])
            6'h00:              return (i[5:0] == 6'h20) || (i[5:0] == 6'h22) ||
                                       (i[5:0] == 6'h24) || (i[5:0] == 6'h25);
            6'h23, 6'h2B, 6'h04: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (r == 5'd0)                 return 32'd0;
        if (wb_en && wb_addr == r)     return wb_data;
        return m_regs[r];
    endfunction

    function automatic exp_t ref_expect(input logic [31:0] i);
        exp_t e;
        logic [31:0] sext;
        sext  = {{16{i[15]}}, i[15:0]};
        e.op  = i[31:26];
        e.fn  = (i[31:26] == 6'h00) ? i[5:0] : 6'd0;
        e.a   = ref_read(i[25:21]);
        e.b   = ref_read(i[20:16]);
        e.sd  = 32'd0;
        e.dst = 5'd0;
        case (i[31:26])
            6'h23:   begin e.b = sext; e.dst = i[20:16]; end
            6'h2B:   begin e.sd = ref_read(i[20:16]); e.b = sext; end
            6'h04:   ;
            default: e.dst = i[15:11];
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic rdy,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic acc;
        logic leg;
        exp_t e;
        if_valid = v;
        if_instr = instr;
        ex_ready = rdy;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        @(negedge clk);
        checkOutput("if_ready", {31'd0, if_ready}, {31'd0, (!m_ev || ex_ready)});
        checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, m_ev});
        checkOutput("illegal", {31'd0, illegal}, {31'd0, m_ill});
        checkOutput("issue_count", 32'(issue_count), 32'(m_cnt));
        if (ex_valid) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = sb[0];
                checkOutput("sb_opcode", 32'(opcode), 32'(e.op));
                checkOutput("sb_funct", 32'(funct), 32'(e.fn));
                checkOutput("sb_in1", in1, e.a);
                checkOutput("sb_in2", in2, e.b);
                checkOutput("sb_store", store_data, e.sd);
                checkOutput("sb_dest", 32'(dest_reg), 32'(e.dst));
                if (ex_ready) void'(sb.pop_front());
            end
        end
        acc = if_valid && (!m_ev || ex_ready);
        leg = ref_legal(if_instr);
        if (acc && leg) sb.push_back(ref_expect(if_instr));
        @(posedge clk);
        m_ill = acc && !leg;
        if (acc && leg) begin
            m_ev  = 1'b1;
            m_cnt = m_cnt + 1'b1;
        end else if (ex_ready) begin
            m_ev = 1'b0;
        end
        if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'd0, rdy, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic issue(input logic [31:0] instr, input logic rdy);
        applyStimulus(1'b1, instr, rdy, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic doReset();
        if_valid = 1'b0;
        ex_ready = 1'b0;
        wb_en    = 1'b0;
        rst_n    = 1'b0;
        #2;
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("rst_count", 32'(issue_count), 32'd0);
        checkOutput("rst_in1", in1, 32'd0);
        checkOutput("rst_in2", in2, 32'd0);
        checkOutput("rst_store", store_data, 32'd0);
        checkOutput("rst_dest", 32'(dest_reg), 32'd0);
        checkOutput("rst_opfn", {20'd0, opcode, funct}, 32'd0);
        sb.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ev  = 1'b0;
        m_ill = 1'b0;
        m_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1;
        doReset();

        // Register setup and basic R-type / load / store / branch issue
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd3);
        issue(32'h00221820, 1'b1);
        checkOutput("add_in1", in1, 32'd5);
        checkOutput("add_in2", in2, 32'd3);
        checkOutput("add_funct", 32'(funct), 32'h20);
        checkOutput("add_dest", 32'(dest_reg), 32'd3);
        checkOutput("add_count", 32'(issue_count), 32'd1);
        issue(32'h8C24FFFC, 1'b1);
        checkOutput("lw_in2", in2, 32'hFFFFFFFC);
        checkOutput("lw_dest", 32'(dest_reg), 32'd4);
        issue(32'hAC220008, 1'b1);
        checkOutput("sw_in2", in2, 32'd8);
        checkOutput("sw_store", store_data, 32'd3);
        checkOutput("sw_dest", 32'(dest_reg), 32'd0);
        issue(32'h10220010, 1'b1);
        idle(1'b1);

        // Stall: the held ADD stays frozen while fetch keeps offering SUB
        issue(32'h00223820, 1'b0);
        for (int k = 0; k < 5; k++) issue(32'h00414022, 1'b0);
        issue(32'h00414022, 1'b1);
        checkOutput("stall_release_dest", 32'(dest_reg), 32'd8);
        checkOutput("stall_release_in1", in1, 32'd3);
        idle(1'b1);

        // Same-cycle bypass, then r0 write is discarded
        applyStimulus(1'b1, 32'h00202825, 1'b1, 1'b1, 5'd1, 32'h0000DEAD);
        checkOutput("byp_in1", in1, 32'h0000DEAD);
        checkOutput("byp_in2", in2, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h00001234);
        issue(32'h00003020, 1'b1);
        checkOutput("r0_in1", in1, 32'd0);
        idle(1'b1);

        // Illegal opcode and illegal R-type funct
        issue(32'hFC000000, 1'b1);
        checkOutput("ill_pulse", {31'd0, illegal}, 32'd1);
        checkOutput("ill_ex_valid", {31'd0, ex_valid}, 32'd0);
        idle(1'b1);
        issue(32'h00221821, 1'b1);
        idle(1'b1);

        // Asynchronous reset in the middle of a stall
        issue(32'h00221820, 1'b0);
        issue(32'h00414022, 1'b0);
        doReset();
        issue(32'h00221820, 1'b1);
        checkOutput("post_rst_in1", in1, 32'd0);
        checkOutput("post_rst_in2", in2, 32'd0);
        idle(1'b1);

        // Counter wrap after 2^COUNT_W issues
        doReset();
        for (int k = 0; k < 16; k++) begin
            issue({6'h00, 5'd1, 5'd2, 5'(k), 5'd0, 6'h24}, 1'b1);
            if (k == 14) checkOutput("count_15", 32'(issue_count), 32'd15);
        end
        checkOutput("count_wrap", 32'(issue_count), 32'd0);
        idle(1'b1);
        idle(1'b1);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
